// File: rtl/super_pkg.sv
// Shared types for the turbo/reset supervisor: FSM state encoding and counter width.
package super_pkg;

    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT_BUS,
        S_REQ,
        S_RST
    } state_e;

endpackage

// File: rtl/super_mode_ctrl.sv
// Turbo-state owner, clock-switch sequencer and stretched CPU reset generator.
// Optional safe-mode lock is built when SUPER_MODE_SAFE_LOCK_EN is defined.
module super_mode_ctrl
    import super_pkg::*;
#(
    parameter int unsigned RST_HOLD_CYCLES = 1024,
    parameter int unsigned SWITCH_TIMEOUT  = 4096,
    parameter logic        POR_TURBO       = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic turbo_toggle,
    input  logic sys_reset_req,
    input  logic sw_turbo_wr,
    input  logic sw_turbo_val,
    input  logic safe_mode,
    input  logic bus_idle,
    input  logic clk_switch_ack,
    output logic turbo_enabled,
    output logic clk_switch_req,
    output logic clk_switch_target,
    output logic cpu_reset,
    output logic reset_busy,
    output logic switch_err
);

    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RST_HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(SWITCH_TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             turbo_q, turbo_d;
    logic             pend_q, pend_d;
    logic             tgt_q, tgt_d;
    logic             req_q, req_d;
    logic             target_q, target_d;
    logic             cpu_rst_q, cpu_rst_d;
    logic             err_q, err_d;

    logic             toggle_ok;
    logic             wr_ok;
    logic             force_drop;

`ifdef SUPER_MODE_SAFE_LOCK_EN
    // In safe mode only a request for the slow clock may get through.
    always_comb begin
        toggle_ok  = turbo_toggle && !safe_mode;
        wr_ok      = sw_turbo_wr && !(safe_mode && sw_turbo_val);
        force_drop = safe_mode && turbo_q && (state_q == S_IDLE);
    end
`else
    logic unused_safe_mode;
    assign unused_safe_mode = safe_mode;

    always_comb begin
        toggle_ok  = turbo_toggle;
        wr_ok      = sw_turbo_wr;
        force_drop = 1'b0;
    end
`endif

    always_comb begin
        // NOTE: every _d gets a default first so no path through the block can infer a latch.
        state_d  = state_q;
        cnt_d    = cnt_q;
        turbo_d  = turbo_q;
        pend_d   = pend_q;
        tgt_d    = tgt_q;
        req_d    = req_q;
        target_d = target_q;
        err_d    = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (pend_q) begin
                    if (tgt_q == turbo_q) pend_d  = 1'b0;
                    else                  state_d = S_WAIT_BUS;
                end
            end
            S_WAIT_BUS: begin
                // A change cancelled while waiting for the bus returns without a handshake.
                if (!pend_q || (tgt_q == turbo_q)) begin
                    pend_d  = 1'b0;
                    state_d = S_IDLE;
                end else if (bus_idle) begin
                    state_d  = S_REQ;
                    req_d    = 1'b1;
                    target_d = tgt_q;
                    pend_d   = 1'b0;
                    cnt_d    = '0;
                end
            end
            S_REQ: begin
                if (clk_switch_ack) begin
                    turbo_d = target_q;
                    req_d   = 1'b0;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == TMO_LAST) begin
                    req_d   = 1'b0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_RST: begin
                if (cnt_q == RST_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                state_d = S_RST;
                cnt_d   = '0;
            end
        endcase

        // New events override the pend clear above; the target is frozen during a handshake.
        if (state_q != S_REQ) begin
            if (wr_ok) begin
                tgt_d  = sw_turbo_val;
                pend_d = 1'b1;
            end else if (toggle_ok) begin
                tgt_d  = pend_q ? ~tgt_q : ~turbo_q;
                pend_d = 1'b1;
            end
        end

        if (force_drop) begin
            tgt_d  = 1'b0;
            pend_d = 1'b1;
        end

        if (sys_reset_req) begin
            state_d = S_RST;
            cnt_d   = '0;
            req_d   = 1'b0;
            err_d   = 1'b0;
            turbo_d = turbo_q;
        end

        cpu_rst_d = (state_d == S_RST);
    end

    always_ff @(posedge clk) begin
        // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
        if (rst) begin
            state_q   <= S_RST;
            cnt_q     <= '0;
            turbo_q   <= POR_TURBO;
            pend_q    <= 1'b0;
            tgt_q     <= POR_TURBO;
            req_q     <= 1'b0;
            target_q  <= POR_TURBO;
            cpu_rst_q <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            turbo_q   <= turbo_d;
            pend_q    <= pend_d;
            tgt_q     <= tgt_d;
            req_q     <= req_d;
            target_q  <= target_d;
            cpu_rst_q <= cpu_rst_d;
            err_q     <= err_d;
        end
    end

    assign turbo_enabled     = turbo_q;
    assign clk_switch_req    = req_q;
    assign clk_switch_target = target_q;
    assign cpu_reset         = cpu_rst_q;
    assign reset_busy        = cpu_rst_q;
    assign switch_err        = err_q;

endmodule

// File: tb/tb_super_mode_ctrl.sv
// Directed plus randomized bench for super_mode_ctrl; the random phase predicts the committed
// turbo state from the event rules alone (last write wins, toggle inverts the effective target).
module tb_super_mode_ctrl;

    localparam int H = 8;
    localparam int T = 16;

    logic clk = 1'b0;
    logic rst;
    logic turbo_toggle;
    logic sys_reset_req;
    logic sw_turbo_wr;
    logic sw_turbo_val;
    logic safe_mode;
    logic bus_idle;
    logic clk_switch_ack;
    logic turbo_enabled;
    logic clk_switch_req;
    logic clk_switch_target;
    logic cpu_reset;
    logic reset_busy;
    logic switch_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic turbo_m;

    always #5 clk = ~clk;

    super_mode_ctrl #(
        .RST_HOLD_CYCLES(H),
        .SWITCH_TIMEOUT (T),
        .POR_TURBO      (1'b1)
    ) dut (
        .clk              (clk),
        .rst              (rst),
        .turbo_toggle     (turbo_toggle),
        .sys_reset_req    (sys_reset_req),
        .sw_turbo_wr      (sw_turbo_wr),
        .sw_turbo_val     (sw_turbo_val),
        .safe_mode        (safe_mode),
        .bus_idle         (bus_idle),
        .clk_switch_ack   (clk_switch_ack),
        .turbo_enabled    (turbo_enabled),
        .clk_switch_req   (clk_switch_req),
        .clk_switch_target(clk_switch_target),
        .cpu_reset        (cpu_reset),
        .reset_busy       (reset_busy),
        .switch_err       (switch_err)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // All driving and sampling happens on the falling edge.
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_toggle();
        turbo_toggle = 1'b1;
        cyc(1);
        turbo_toggle = 1'b0;
    endtask

    task automatic pulse_sysrst();
        sys_reset_req = 1'b1;
        cyc(1);
        sys_reset_req = 1'b0;
    endtask

    task automatic wait_req(input string tag, input int budget);
        int n;
        n = 0;
        while (!clk_switch_req && n < budget) begin
            cyc(1);
            n++;
        end
        check({tag, " req rise"}, clk_switch_req, 1'b1);
    endtask

    task automatic measure_reset(input string tag);
        int n;
        n = 0;
        while (cpu_reset && n < H + 4) begin
            check({tag, " busy"}, reset_busy, 1'b1);
            n++;
            cyc(1);
        end
        check({tag, " length"}, n, H);
        check({tag, " busy low"}, reset_busy, 1'b0);
    endtask

    task automatic measure_timeout(input string tag);
        int n;
        n = 0;
        while (clk_switch_req && n < T + 4) begin
            check({tag, " err idle"}, switch_err, 1'b0);
            n++;
            cyc(1);
        end
        check({tag, " req length"}, n, T);
        check({tag, " err pulse"}, switch_err, 1'b1);
        cyc(1);
        check({tag, " err one cycle"}, switch_err, 1'b0);
    endtask

    task automatic do_switch(input string tag, input logic exp_tgt);
        wait_req(tag, 6);
        check({tag, " target"}, clk_switch_target, exp_tgt);
        cyc(1);
        clk_switch_ack = 1'b1;
        cyc(1);
        clk_switch_ack = 1'b0;
        check({tag, " turbo"}, turbo_enabled, exp_tgt);
        check({tag, " req drop"}, clk_switch_req, 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        turbo_toggle   = 1'b0;
        sys_reset_req  = 1'b0;
        sw_turbo_wr    = 1'b0;
        sw_turbo_val   = 1'b0;
        safe_mode      = 1'b0;
        bus_idle       = 1'b0;
        clk_switch_ack = 1'b0;

        // 1: power-on reset
        cyc(1);
        check("rst cpu_reset", cpu_reset, 1'b1);
        check("rst req", clk_switch_req, 1'b0);
        check("rst err", switch_err, 1'b0);
        check("rst turbo", turbo_enabled, 1'b1);
        rst = 1'b0;
        measure_reset("por");
        check("por turbo", turbo_enabled, 1'b1);

        // 2: toggle waits for bus idle; toggle during handshake is dropped
        pulse_toggle();
        cyc(4);
        check("bus busy no req", clk_switch_req, 1'b0);
        bus_idle = 1'b1;
        cyc(1);
        check("req after bus_idle", clk_switch_req, 1'b1);
        check("req target", clk_switch_target, 1'b0);
        pulse_toggle();
        check("target stable", clk_switch_target, 1'b0);
        cyc(2);
        clk_switch_ack = 1'b1;
        cyc(1);
        clk_switch_ack = 1'b0;
        check("ack turbo", turbo_enabled, 1'b0);
        check("ack req low", clk_switch_req, 1'b0);
        cyc(4);
        check("dropped toggle", clk_switch_req, 1'b0);

        // 3: two toggles cancel; simultaneous write beats toggle
        bus_idle = 1'b0;
        pulse_toggle();
        cyc(1);
        pulse_toggle();
        cyc(3);
        bus_idle = 1'b1;
        cyc(6);
        check("cancel no req", clk_switch_req, 1'b0);
        check("cancel turbo", turbo_enabled, 1'b0);
        turbo_toggle = 1'b1;
        sw_turbo_wr  = 1'b1;
        sw_turbo_val = 1'b0;
        cyc(1);
        turbo_toggle = 1'b0;
        sw_turbo_wr  = 1'b0;
        cyc(6);
        check("wr wins no req", clk_switch_req, 1'b0);
        check("wr wins turbo", turbo_enabled, 1'b0);

        // 4: timeout, then ack on the final timeout cycle wins
        pulse_toggle();
        wait_req("tmo", 6);
        measure_timeout("tmo");
        check("tmo turbo", turbo_enabled, 1'b0);
        pulse_toggle();
        wait_req("late ack", 6);
        cyc(T - 1);
        check("late ack still req", clk_switch_req, 1'b1);
        clk_switch_ack = 1'b1;
        cyc(1);
        clk_switch_ack = 1'b0;
        check("late ack turbo", turbo_enabled, 1'b1);
        check("late ack no err", switch_err, 1'b0);

        // 5: sys reset during handshake; restart during hold; pending change served after
        pulse_toggle();
        wait_req("sysrst", 6);
        cyc(2);
        sys_reset_req = 1'b1;
        cyc(1);
        sys_reset_req = 1'b0;
        check("sysrst req drop", clk_switch_req, 1'b0);
        check("sysrst cpu_reset", cpu_reset, 1'b1);
        measure_reset("sysrst");
        check("sysrst turbo kept", turbo_enabled, 1'b1);
        cyc(3);
        check("sysrst nothing pend", clk_switch_req, 1'b0);
        pulse_sysrst();
        cyc(2);
        pulse_toggle();
        pulse_sysrst();
        measure_reset("restart");
        do_switch("after rst", 1'b0);
        pulse_toggle();
        do_switch("back to turbo", 1'b1);

        // 6: safe mode
        safe_mode = 1'b1;
`ifdef SUPER_MODE_SAFE_LOCK_EN
        do_switch("safe drop", 1'b0);
        pulse_toggle();
        cyc(5);
        check("safe toggle ignored", clk_switch_req, 1'b0);
        sw_turbo_wr  = 1'b1;
        sw_turbo_val = 1'b1;
        cyc(1);
        sw_turbo_wr  = 1'b0;
        cyc(5);
        check("safe wr1 ignored", clk_switch_req, 1'b0);
        check("safe turbo", turbo_enabled, 1'b0);
`else
        cyc(6);
        check("safe no effect req", clk_switch_req, 1'b0);
        check("safe no effect turbo", turbo_enabled, 1'b1);
        pulse_toggle();
        do_switch("safe toggle works", 1'b0);
`endif
        safe_mode = 1'b0;
        turbo_m   = 1'b0;

        // Random event bursts against the effective-target model
        for (int t = 0; t < 24; t++) begin
            logic e;
            int   nev;
            int   kind;
            int   d;
            e        = turbo_m;
            bus_idle = 1'b0;
            nev      = $urandom_range(1, 4);
            for (int k = 0; k < nev; k++) begin
                kind         = $urandom_range(0, 3);
                turbo_toggle = (kind == 1) || (kind == 3);
                sw_turbo_wr  = (kind >= 2);
                sw_turbo_val = 1'($urandom_range(0, 1));
                if (sw_turbo_wr)       e = sw_turbo_val;
                else if (turbo_toggle) e = ~e;
                cyc(1);
                turbo_toggle = 1'b0;
                sw_turbo_wr  = 1'b0;
                if ($urandom_range(0, 1) == 1) cyc(1);
            end
            cyc(2);
            check("rand hold", clk_switch_req, 1'b0);
            bus_idle = 1'b1;
            if (e != turbo_m) begin
                wait_req("rand", 3);
                check("rand target", clk_switch_target, e);
                if ($urandom_range(0, 3) == 0) begin
                    measure_timeout("rand tmo");
                    check("rand tmo turbo", turbo_enabled, turbo_m);
                end else begin
                    d = $urandom_range(0, 5);
                    cyc(d);
                    clk_switch_ack = 1'b1;
                    cyc(1);
                    clk_switch_ack = 1'b0;
                    check("rand turbo", turbo_enabled, e);
                    check("rand req drop", clk_switch_req, 1'b0);
                    turbo_m = e;
                end
            end else begin
                cyc(4);
                check("rand no req", clk_switch_req, 1'b0);
                check("rand turbo kept", turbo_enabled, turbo_m);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
